// File: rtl/motor_fault_pkg.sv
// +--------------------------------------------------------------------+
// | motor_fault_pkg : shared types/constants for motor_fault_supervisor |
// | Macro: SUPERVISOR_OTW_FAULT_EN (adds OTW cause bit)   Rev 1.0       |
// +--------------------------------------------------------------------+
`default_nettype none

package motor_fault_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_BRAKE = 2'd1,
    ST_COAST = 2'd2
  } state_t;

  localparam int C_DRV  = 0;
  localparam int C_HALL = 1;
  localparam int C_ENC  = 2;
  localparam int C_SW   = 3;
  localparam int C_WDT  = 4;

`ifdef SUPERVISOR_OTW_FAULT_EN
  localparam int C_OTW   = 5;
  localparam int CAUSE_W = 6;
`else
  localparam int CAUSE_W = 5;
`endif

  // Bits needed to hold 0..max_val; never less than one.
  function automatic int cnt_w(input int unsigned max_val);
    return (max_val == 0) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fault_channel_fsm.sv
// +--------------------------------------------------------------------+
// | fault_channel_fsm : one channel's filters, watchdog, causes, FSM    |
// | Macro: SUPERVISOR_OTW_FAULT_EN                        Rev 1.0       |
// +--------------------------------------------------------------------+
`default_nettype none

module fault_channel_fsm
  import motor_fault_pkg::*;
#(
  parameter int FILTER_CYCLES = 16,
  parameter int WDT_CYCLES    = 100000,
  parameter int BRAKE_CYCLES  = 50000
) (
  input  logic               clk,
  input  logic               rst_n_i,
  input  logic               drv_act_i,
  input  logic               hall_act_i,
  input  logic               enc_act_i,
  input  logic               otw_act_i,
  input  logic               cmd_valid_i,
  input  logic               sw_fault_i,
  input  logic               clear_req_i,
  output logic               fault_o,
  output logic               brake_o,
  output logic [CAUSE_W-1:0] cause_o,
  output logic               otw_o
);

  localparam int FW = cnt_w(FILTER_CYCLES);
  localparam int WW = cnt_w(WDT_CYCLES);
  localparam int BW = cnt_w(BRAKE_CYCLES);
  localparam logic [FW-1:0] FLT_MAX  = FW'(FILTER_CYCLES);
  localparam logic [WW-1:0] WDT_LOAD = WW'(WDT_CYCLES);
  localparam logic [BW-1:0] BRK_LAST = BW'(BRAKE_CYCLES - 1);

  // Filter slots: 0 drv, 1 hall, 2 enc, 3 otw
  logic [3:0]    w_act;
  logic [3:0]    w_flt;
  logic [FW-1:0] flt_q [4];

  assign w_act = {otw_act_i, enc_act_i, hall_act_i, drv_act_i};

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < 4; i++) flt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!w_act[i])               flt_q[i] <= '0;
        else if (flt_q[i] != FLT_MAX) flt_q[i] <= flt_q[i] + FW'(1);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) w_flt[i] = (flt_q[i] == FLT_MAX);
  end

  state_t               state_q;
  logic                 fault_q;
  logic                 brake_q;
  logic                 otw_q;
  logic [CAUSE_W-1:0]   cause_q;
  logic [CAUSE_W-1:0]   cause_d;
  logic [CAUSE_W-1:0]   w_set;
  logic [WW-1:0]        wdt_q;
  logic [BW-1:0]        brk_q;
  logic                 w_wdt_exp;

  // Expiry is the decrement into zero; a kick on that same cycle reloads instead.
  assign w_wdt_exp = (WDT_CYCLES != 0) && (state_q == ST_RUN) &&
                     (wdt_q == WW'(1)) && !cmd_valid_i;

  always_comb begin
    w_set         = '0;
    w_set[C_DRV]  = w_flt[0];
    w_set[C_HALL] = w_flt[1];
    w_set[C_ENC]  = w_flt[2];
    w_set[C_SW]   = sw_fault_i;
    w_set[C_WDT]  = w_wdt_exp;
`ifdef SUPERVISOR_OTW_FAULT_EN
    w_set[C_OTW]  = w_flt[3];
`endif
    cause_d = cause_q | w_set;
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_COAST;
      fault_q <= 1'b1;
      brake_q <= 1'b0;
      otw_q   <= 1'b0;
      cause_q <= '0;
      wdt_q   <= WDT_LOAD;
      brk_q   <= '0;
    end else begin
      otw_q   <= w_flt[3];
      cause_q <= cause_d;
      case (state_q)
        ST_RUN: begin
          if (cmd_valid_i)        wdt_q <= WDT_LOAD;
          else if (wdt_q != '0)   wdt_q <= wdt_q - WW'(1);
          if (|w_set) begin
            fault_q <= 1'b1;
            brk_q   <= '0;
            if (BRAKE_CYCLES == 0) begin
              state_q <= ST_COAST;
              brake_q <= 1'b0;
            end else begin
              state_q <= ST_BRAKE;
              brake_q <= 1'b1;
            end
          end
        end
        ST_BRAKE: begin
          wdt_q <= WDT_LOAD;
          if (brk_q == BRK_LAST) begin
            state_q <= ST_COAST;
            brake_q <= 1'b0;
          end else begin
            brk_q <= brk_q + BW'(1);
          end
        end
        default: begin
          // COAST (and any illegal encoding): release only with every source quiet.
          wdt_q   <= WDT_LOAD;
          state_q <= ST_COAST;
          fault_q <= 1'b1;
          brake_q <= 1'b0;
          if (clear_req_i && !(|w_set)) begin
            state_q <= ST_RUN;
            fault_q <= 1'b0;
            cause_q <= '0;
          end
        end
      endcase
    end
  end

  assign fault_o = fault_q;
  assign brake_o = brake_q;
  assign cause_o = cause_q;
  assign otw_o   = otw_q;

endmodule

`default_nettype wire

// File: rtl/motor_fault_supervisor.sv
// +--------------------------------------------------------------------+
// | motor_fault_supervisor : per-channel motor fault/brake supervisor   |
// | Macro: SUPERVISOR_OTW_FAULT_EN                        Rev 1.0       |
// +--------------------------------------------------------------------+
`default_nettype none

module motor_fault_supervisor
  import motor_fault_pkg::*;
#(
  parameter int NUM_CH        = 5,
  parameter int FILTER_CYCLES = 16,
  parameter int WDT_CYCLES    = 100000,
  parameter int BRAKE_CYCLES  = 50000
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_CH-1:0]         status_driver_fault_n,
  input  logic [NUM_CH-1:0]         status_driver_otw_n,
  input  logic [NUM_CH-1:0]         status_hall_fault_n,
  input  logic [NUM_CH-1:0]         status_encoder_fault_n,
  input  logic [NUM_CH-1:0]         cmd_valid,
  input  logic                      sw_fault,
  input  logic [NUM_CH-1:0]         clear_req,
  output logic [NUM_CH-1:0]         fault,
  output logic [NUM_CH-1:0]         brake,
  output logic [CAUSE_W*NUM_CH-1:0] cause,
  output logic [NUM_CH-1:0]         otw
);

  localparam int PW = 4 * NUM_CH;

  logic [PW-1:0] w_pins;
  logic [PW-1:0] meta_q;
  logic [PW-1:0] sync_q;
  logic [PW-1:0] w_act;

  assign w_pins = {status_encoder_fault_n, status_hall_fault_n,
                   status_driver_otw_n, status_driver_fault_n};

  // Synchronisers park at the inactive (high) level during reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= w_pins;
      sync_q <= meta_q;
    end
  end

  assign w_act = ~sync_q;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    fault_channel_fsm #(
      .FILTER_CYCLES (FILTER_CYCLES),
      .WDT_CYCLES    (WDT_CYCLES),
      .BRAKE_CYCLES  (BRAKE_CYCLES)
    ) u_ch (
      .clk         (clk),
      .rst_n_i     (reset_n),
      .drv_act_i   (w_act[0*NUM_CH + k]),
      .otw_act_i   (w_act[1*NUM_CH + k]),
      .hall_act_i  (w_act[2*NUM_CH + k]),
      .enc_act_i   (w_act[3*NUM_CH + k]),
      .cmd_valid_i (cmd_valid[k]),
      .sw_fault_i  (sw_fault),
      .clear_req_i (clear_req[k]),
      .fault_o     (fault[k]),
      .brake_o     (brake[k]),
      .cause_o     (cause[k*CAUSE_W +: CAUSE_W]),
      .otw_o       (otw[k])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_motor_fault_supervisor.sv
// +--------------------------------------------------------------------+
// | tb_motor_fault_supervisor : directed bench for the supervisor       |
// | Macro: SUPERVISOR_OTW_FAULT_EN                        Rev 1.0       |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_motor_fault_supervisor;
  import motor_fault_pkg::*;

  localparam int NCH = 5;
  localparam int CW  = CAUSE_W;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [NCH-1:0]   drv_n, otw_n, hall_n, enc_n;
  logic [NCH-1:0]   cmd_valid, clear_req;
  logic             sw_fault;
  logic [NCH-1:0]   fault, brake, otw;
  logic [CW*NCH-1:0] cause;

  int n_tests = 0;
  int n_fail  = 0;

  logic [CW-1:0]     e_drv, e_hall, e_sw, e_wdt;
  logic [CW*NCH-1:0] all_sw;

  motor_fault_supervisor #(
    .NUM_CH        (NCH),
    .FILTER_CYCLES (16),
    .WDT_CYCLES    (50),
    .BRAKE_CYCLES  (20)
  ) dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .status_driver_fault_n  (drv_n),
    .status_driver_otw_n    (otw_n),
    .status_hall_fault_n    (hall_n),
    .status_encoder_fault_n (enc_n),
    .cmd_valid              (cmd_valid),
    .sw_fault               (sw_fault),
    .clear_req              (clear_req),
    .fault                  (fault),
    .brake                  (brake),
    .cause                  (cause),
    .otw                    (otw)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] ch_cause(input int k);
    return cause[k*CW +: CW];
  endfunction

  initial begin
    e_drv  = CW'(1) << C_DRV;
    e_hall = CW'(1) << C_HALL;
    e_sw   = CW'(1) << C_SW;
    e_wdt  = CW'(1) << C_WDT;
    for (int k = 0; k < NCH; k++) all_sw[k*CW +: CW] = e_sw;

    reset_n = 1'b0;
    drv_n = '1; otw_n = '1; hall_n = '1; enc_n = '1;
    cmd_valid = '0; clear_req = '0; sw_fault = 1'b0;
    tick(3);
    check("rst_fault", 64'(fault), 64'h1F);
    check("rst_brake", 64'(brake), 64'h0);
    check("rst_cause", 64'(cause), 64'h0);
    check("rst_otw",   64'(otw),   64'h0);
    reset_n = 1'b1;
    tick(3);
    check("post_rst_fault", 64'(fault), 64'h1F);

    // Release ch2 only
    clear_req = 5'b00100;
    tick();
    clear_req = '0;
    check("clr_ch2_fault", 64'(fault), 64'b11011);
    check("clr_ch2_cause", 64'(cause), 64'h0);

    // Watchdog on ch2: kicks every 40 cycles hold it off
    for (int i = 0; i < 3; i++) begin
      tick(39);
      cmd_valid[2] = 1'b1;
      tick();
      cmd_valid[2] = 1'b0;
    end
    check("wdt_kicked", 64'(fault[2]), 64'h0);
    tick(49);
    check("wdt_pre_expiry", 64'(fault[2]), 64'h0);
    cmd_valid[2] = 1'b1;
    tick();
    cmd_valid[2] = 1'b0;
    check("wdt_expiry_kick", 64'(fault[2]), 64'h0);
    tick(49);
    check("wdt_49", 64'(fault[2]), 64'h0);
    tick();
    check("wdt_fault", 64'(fault[2]), 64'h1);
    check("wdt_brake", 64'(brake[2]), 64'h1);
    check("wdt_cause", 64'(ch_cause(2)), 64'(e_wdt));

    // Driver fault filter on ch0
    cmd_valid[0] = 1'b1;
    clear_req[0] = 1'b1;
    tick();
    clear_req = '0;
    check("clr_ch0", 64'(fault[0]), 64'h0);
    drv_n[0] = 1'b0;
    tick(15);
    drv_n[0] = 1'b1;
    tick(10);
    check("glitch15_cause", 64'(ch_cause(0)), 64'h0);
    check("glitch15_fault", 64'(fault[0]), 64'h0);
    drv_n[0] = 1'b0;
    tick(16);
    drv_n[0] = 1'b1;
    tick(2);
    check("flt_latency", 64'(fault[0]), 64'h0);
    tick();
    check("drv_fault", 64'(fault[0]), 64'h1);
    check("drv_brake", 64'(brake[0]), 64'h1);
    check("drv_cause", 64'(ch_cause(0)), 64'(e_drv));
    tick(19);
    check("brake_hold", 64'(brake[0]), 64'h1);
    tick();
    check("brake_end", 64'(brake[0]), 64'h0);
    check("coast_fault", 64'(fault[0]), 64'h1);
    check("ch2_coast", 64'({fault[2], brake[2]}), 64'b10);

    // Hall fault held while coasting: clear rejected
    hall_n[0] = 1'b0;
    tick(20);
    check("cause_accum", 64'(ch_cause(0)), 64'(e_drv | e_hall));
    clear_req[0] = 1'b1;
    tick();
    clear_req = '0;
    check("clr_rej_fault", 64'(fault[0]), 64'h1);
    check("clr_rej_cause", 64'(ch_cause(0)), 64'(e_drv | e_hall));
    hall_n[0] = 1'b1;
    tick(20);
    clear_req[0] = 1'b1;
    tick();
    clear_req = '0;
    check("clr_ok_fault", 64'(fault[0]), 64'h0);
    check("clr_ok_cause", 64'(ch_cause(0)), 64'h0);

    // Software stop on all channels
    cmd_valid = '1;
    clear_req = '1;
    tick();
    clear_req = '0;
    check("all_run_fault", 64'(fault), 64'h0);
    check("all_run_cause", 64'(cause), 64'h0);
    sw_fault = 1'b1;
    tick();
    check("sw_fault", 64'(fault), 64'h1F);
    check("sw_brake", 64'(brake), 64'h1F);
    check("sw_cause", 64'(cause), 64'(all_sw));
    tick(20);
    check("sw_coast", 64'(brake), 64'h0);
    clear_req = '1;
    tick();
    clear_req = '0;
    check("sw_clr_rej", 64'(fault), 64'h1F);
    check("sw_clr_rej_cause", 64'(cause), 64'(all_sw));
    sw_fault = 1'b0;
    clear_req = '1;
    tick();
    clear_req = '0;
    check("sw_clr_ok", 64'(fault), 64'h0);
    check("sw_clr_cause", 64'(cause), 64'h0);

    // Asynchronous reset in the middle of braking
    sw_fault = 1'b1;
    tick();
    sw_fault = 1'b0;
    tick(5);
    check("mid_brake", 64'(brake), 64'h1F);
    reset_n = 1'b0;
    #1;
    check("async_rst_fault", 64'(fault), 64'h1F);
    check("async_rst_brake", 64'(brake), 64'h0);
    check("async_rst_cause", 64'(cause), 64'h0);
    tick(2);
    reset_n = 1'b1;
    tick(3);
    check("rel_fault", 64'(fault), 64'h1F);
    check("rel_cause", 64'(cause), 64'h0);
    clear_req = 5'b00010;
    tick();
    clear_req = '0;
    check("post_rst_clr", 64'(fault), 64'b11101);

    // Over-temperature warning on ch1 (running)
    otw_n[1] = 1'b0;
    tick(18);
    check("otw_latency", 64'(otw), 64'h0);
    tick();
    check("otw_on", 64'(otw), 64'b00010);
`ifdef SUPERVISOR_OTW_FAULT_EN
    check("otw_fault", 64'(fault), 64'h1F);
`else
    check("otw_fault", 64'(fault), 64'b11101);
`endif
    otw_n[1] = 1'b1;
    tick(5);
    check("otw_off", 64'(otw), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
